// File: rtl/io_output_bank_pkg.sv
// Shared definitions for the memory-mapped output-port bank: write-op aliases and timer sizing.
package io_output_bank_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OP_W   = 2;

  // Address alias selecting what a write does to the addressed port
  typedef enum logic [OP_W-1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_PULSE = 2'b11
  } op_e;

  // Pulse down-counter width: holds PULSE_LEN-1, never narrower than one bit
  function automatic int unsigned cnt_bits(input int unsigned len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/io_output_bank_pulse_port.sv
// One output port: data register plus pulse mask, down-counter and busy flag.
module io_output_bank_pulse_port
  import io_output_bank_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PULSE_LEN = 8
) (
  input  logic             io_clk,
  input  logic             clr,
  input  logic             we,
  input  op_e              op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] port_q,
  output logic             busy_q
);

  localparam int unsigned     CNT_W    = cnt_bits(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] port_d;
  logic [WIDTH-1:0] mask_d;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_d;
  logic             expire;

  always_ff @(posedge io_clk or posedge clr) begin
    if (clr) begin
      port_q <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      port_q <= port_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // Expiry is resolved first so a same-cycle op acts on the post-expiry value
  always_comb begin
    expire = busy_q && (cnt_q == '0);
    port_d = port_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    if (expire) begin
      port_d = port_q & ~mask_q;
      mask_d = '0;
      busy_d = 1'b0;
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (we) begin
      unique case (op)
        OP_WRITE: begin
          port_d = data;
          mask_d = '0;
          cnt_d  = '0;
          busy_d = 1'b0;
        end
        OP_SET:   port_d = port_d | data;
        OP_CLEAR: port_d = port_d & ~data;
        OP_PULSE: begin
          port_d = port_d | data;
          mask_d = mask_d | data;
          cnt_d  = CNT_LOAD;
          busy_d = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/io_output_bank.sv
// Memory-mapped output-port bank: address decode, per-port write strobes and combinational read-back.
module io_output_bank
  import io_output_bank_pkg::*;
#(
  parameter int unsigned        WIDTH     = 32,
  parameter int unsigned        IDX_BITS  = 2,
  parameter int unsigned        NUM_PORTS = 4,
  parameter int unsigned        DEC_BITS  = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h80,
  parameter int unsigned        PULSE_LEN = 8
) (
  input  logic                       io_clk,
  input  logic                       clr,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [WIDTH-1:0]           datain,
  input  logic                       write_io_enable,
  output logic [NUM_PORTS*WIDTH-1:0] out_port,
  output logic [WIDTH-1:0]           read_data,
  output logic [NUM_PORTS-1:0]       pulse_busy
);

  localparam int unsigned SEL_LO = IDX_BITS + 4;
  localparam int unsigned SEL_W  = DEC_BITS - SEL_LO;
  localparam logic [SEL_W-1:0] BASE_SEL = BASE_ADDR[DEC_BITS-1:SEL_LO];

  logic                hit;
  logic [OP_W-1:0]     op_bits;
  logic [IDX_BITS-1:0] idx;
  logic [WIDTH-1:0]    port_q [NUM_PORTS];

  // Upper address bits alias the region and byte-lane bits are don't-care
  logic [ADDR_W-DEC_BITS+1:0] unused_addr;
  assign unused_addr = {addr[ADDR_W-1:DEC_BITS], addr[1:0]};

  assign hit     = (addr[DEC_BITS-1:SEL_LO] == BASE_SEL);
  assign op_bits = addr[IDX_BITS+3:IDX_BITS+2];
  assign idx     = addr[IDX_BITS+1:2];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic we_i;
    assign we_i = write_io_enable && hit && (idx == IDX_BITS'(i));

    io_output_bank_pulse_port #(
      .WIDTH     (WIDTH),
      .PULSE_LEN (PULSE_LEN)
    ) u_port (
      .io_clk (io_clk),
      .clr    (clr),
      .we     (we_i),
      .op     (op_e'(op_bits)),
      .data   (datain),
      .port_q (port_q[i]),
      .busy_q (pulse_busy[i])
    );

    assign out_port[i*WIDTH +: WIDTH] = port_q[i];
  end

  // Unimplemented indices and misses read back as zero
  always_comb begin
    read_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (hit && (idx == IDX_BITS'(i))) read_data = port_q[i];
    end
  end

endmodule
